// File: rtl/enemy_pool.sv
// rtl/enemy_pool.sv - enemy slot pool: lowest-free-slot spawning, per-slot IDLE/ALIVE/EXPLODE FSM
// Optional per-slot multi-hit HP counters are enabled by defining ENEMY_POOL_HP_EN.
module enemy_pool #(
  parameter int MAX_ENEMY_NUM = 10,
  parameter int IDX_BIT_LEN   = 4,
  parameter int X_POS_BIT_LEN = 10,
  parameter int Y_POS_BIT_LEN = 11,
  parameter int SPEED         = 1,
  parameter int SPAWN_PERIOD  = 50,
  parameter int V_DISP        = 480,
  parameter int ENEMY_Y_SIZE  = 100,
  parameter int HP_BIT_LEN    = 3,
  parameter int HP_INIT       = 3,
  parameter int EXPLODE_TICKS = 8,
  parameter int CNT_BIT_LEN   = 4
) (
  input  logic                                   clk_run,
  input  logic                                   rst,
  input  logic                                   en_i,
  input  logic                                   tick_i,
  input  logic [X_POS_BIT_LEN-1:0]               rand_pos_i,
  input  logic [MAX_ENEMY_NUM-1:0]               hit_i,
  output logic [MAX_ENEMY_NUM*X_POS_BIT_LEN-1:0] x_pos_o,
  output logic [MAX_ENEMY_NUM*Y_POS_BIT_LEN-1:0] y_pos_o,
  output logic [2*MAX_ENEMY_NUM-1:0]             state_o,
  output logic                                   spawn_o,
  output logic [IDX_BIT_LEN-1:0]                 spawn_idx_o,
  output logic                                   full_o,
  output logic [CNT_BIT_LEN-1:0]                 kill_num_o,
  output logic [CNT_BIT_LEN-1:0]                 escape_num_o
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_ALIVE   = 2'b01;
  localparam logic [1:0] S_EXPLODE = 2'b10;

  localparam int SC_W  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int EXP_W = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;

  localparam logic [Y_POS_BIT_LEN-1:0] Y_LIMIT = Y_POS_BIT_LEN'(V_DISP + ENEMY_Y_SIZE);
  localparam logic [Y_POS_BIT_LEN-1:0] Y_STEP  = Y_POS_BIT_LEN'(SPEED);

  localparam bit CFG_OK = (2 ** IDX_BIT_LEN >= MAX_ENEMY_NUM) && (EXPLODE_TICKS >= 1) &&
                          (HP_INIT >= 1) && (HP_INIT < 2 ** HP_BIT_LEN) && (SPAWN_PERIOD >= 1) &&
                          (V_DISP + ENEMY_Y_SIZE + SPEED < 2 ** Y_POS_BIT_LEN);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("enemy_pool: invalid parameter set");
    end
  endgenerate

  logic [1:0]               r_state   [MAX_ENEMY_NUM];
  logic [X_POS_BIT_LEN-1:0] r_x       [MAX_ENEMY_NUM];
  logic [Y_POS_BIT_LEN-1:0] r_y       [MAX_ENEMY_NUM];
  logic [EXP_W-1:0]         r_exp_cnt [MAX_ENEMY_NUM];
  logic [SC_W-1:0]          r_spawn_cnt;
  logic                     r_spawn;
  logic [IDX_BIT_LEN-1:0]   r_spawn_idx;
  logic                     r_full;
  logic [CNT_BIT_LEN-1:0]   r_kill_num;
  logic [CNT_BIT_LEN-1:0]   r_escape_num;

  logic [1:0]               w_state_nxt [MAX_ENEMY_NUM];
  logic [X_POS_BIT_LEN-1:0] w_x_nxt     [MAX_ENEMY_NUM];
  logic [Y_POS_BIT_LEN-1:0] w_y_nxt     [MAX_ENEMY_NUM];
  logic [EXP_W-1:0]         w_exp_nxt   [MAX_ENEMY_NUM];
  logic [MAX_ENEMY_NUM-1:0] w_fatal;
  logic [MAX_ENEMY_NUM-1:0] w_kill;
  logic [MAX_ENEMY_NUM-1:0] w_esc;
  logic [CNT_BIT_LEN-1:0]   w_kill_cnt;
  logic [CNT_BIT_LEN-1:0]   w_esc_cnt;
  logic [SC_W-1:0]          w_spawn_cnt_nxt;
  logic                     w_attempt;
  logic                     w_free;
  logic                     w_spawn_go;
  logic [IDX_BIT_LEN-1:0]   w_spawn_idx;

`ifdef ENEMY_POOL_HP_EN
  logic [HP_BIT_LEN-1:0]    r_hp     [MAX_ENEMY_NUM];
  logic [HP_BIT_LEN-1:0]    w_hp_nxt [MAX_ENEMY_NUM];
`endif

  // Free-slot search looks only at registered state, so a slot leaving this cycle waits one cycle.
  always_comb begin
    w_attempt       = en_i && (r_spawn_cnt == SC_W'(SPAWN_PERIOD - 1));
    w_spawn_cnt_nxt = r_spawn_cnt;
    if (en_i) begin
      w_spawn_cnt_nxt = w_attempt ? '0 : r_spawn_cnt + SC_W'(1);
    end
    w_free      = 1'b0;
    w_spawn_idx = '0;
    for (int i = MAX_ENEMY_NUM - 1; i >= 0; i--) begin
      if (r_state[i] == S_IDLE) begin
        w_free      = 1'b1;
        w_spawn_idx = IDX_BIT_LEN'(i);
      end
    end
    w_spawn_go = w_attempt && w_free;
  end

  always_comb begin
    w_kill     = '0;
    w_esc      = '0;
    w_fatal    = '0;
    w_kill_cnt = '0;
    w_esc_cnt  = '0;
    for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
      w_state_nxt[i] = r_state[i];
      w_x_nxt[i]     = r_x[i];
      w_y_nxt[i]     = r_y[i];
      w_exp_nxt[i]   = r_exp_cnt[i];
`ifdef ENEMY_POOL_HP_EN
      w_hp_nxt[i]    = r_hp[i];
      w_fatal[i]     = hit_i[i] && (r_hp[i] == HP_BIT_LEN'(1));
`else
      w_fatal[i]     = hit_i[i];
`endif
      case (r_state[i])
        S_IDLE: begin
          if (w_spawn_go && (w_spawn_idx == IDX_BIT_LEN'(i))) begin
            w_state_nxt[i] = S_ALIVE;
            w_x_nxt[i]     = rand_pos_i;
            w_y_nxt[i]     = '0;
`ifdef ENEMY_POOL_HP_EN
            w_hp_nxt[i]    = HP_BIT_LEN'(HP_INIT);
`endif
          end
        end
        S_ALIVE: begin
          if (w_fatal[i]) begin
            w_state_nxt[i] = S_EXPLODE;
            w_exp_nxt[i]   = EXP_W'(EXPLODE_TICKS - 1);
            w_kill[i]      = 1'b1;
          end else begin
`ifdef ENEMY_POOL_HP_EN
            if (hit_i[i]) begin
              w_hp_nxt[i] = r_hp[i] - HP_BIT_LEN'(1);
            end
`endif
            if (en_i && tick_i) begin
              if (r_y[i] >= Y_LIMIT) begin
                w_state_nxt[i] = S_IDLE;
                w_y_nxt[i]     = '0;
                w_esc[i]       = 1'b1;
              end else begin
                w_y_nxt[i] = r_y[i] + Y_STEP;
              end
            end
          end
        end
        S_EXPLODE: begin
          if (tick_i) begin
            if (r_exp_cnt[i] == '0) begin
              w_state_nxt[i] = S_IDLE;
            end else begin
              w_exp_nxt[i] = r_exp_cnt[i] - EXP_W'(1);
            end
          end
        end
        default: w_state_nxt[i] = S_IDLE;
      endcase
      w_kill_cnt = w_kill_cnt + CNT_BIT_LEN'(w_kill[i]);
      w_esc_cnt  = w_esc_cnt + CNT_BIT_LEN'(w_esc[i]);
    end
  end

  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
        r_state[i]   <= S_IDLE;
        r_x[i]       <= '0;
        r_y[i]       <= '0;
        r_exp_cnt[i] <= '0;
`ifdef ENEMY_POOL_HP_EN
        r_hp[i]      <= '0;
`endif
      end
      r_spawn_cnt  <= '0;
      r_spawn      <= 1'b0;
      r_spawn_idx  <= '0;
      r_full       <= 1'b0;
      r_kill_num   <= '0;
      r_escape_num <= '0;
    end else begin
      for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_x[i]       <= w_x_nxt[i];
        r_y[i]       <= w_y_nxt[i];
        r_exp_cnt[i] <= w_exp_nxt[i];
`ifdef ENEMY_POOL_HP_EN
        r_hp[i]      <= w_hp_nxt[i];
`endif
      end
      r_spawn_cnt  <= w_spawn_cnt_nxt;
      r_spawn      <= w_spawn_go;
      r_spawn_idx  <= w_spawn_go ? w_spawn_idx : '0;
      r_full       <= !w_free;
      r_kill_num   <= w_kill_cnt;
      r_escape_num <= w_esc_cnt;
    end
  end

  always_comb begin
    state_o = '0;
    x_pos_o = '0;
    y_pos_o = '0;
    for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
      state_o[2*i +: 2]                         = r_state[i];
      x_pos_o[i*X_POS_BIT_LEN +: X_POS_BIT_LEN] = r_x[i];
      y_pos_o[i*Y_POS_BIT_LEN +: Y_POS_BIT_LEN] = r_y[i];
    end
    spawn_o      = r_spawn;
    spawn_idx_o  = r_spawn_idx;
    full_o       = r_full;
    kill_num_o   = r_kill_num;
    escape_num_o = r_escape_num;
  end

endmodule
